axi_exdes_core: RTL and testbench



---
 rtl/axi_exdes_core.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_axi_exdes_core.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axi_exdes_core.sv
// axi_exdes_core: self-contained AXI4 example subsystem.
// It contains a master traffic generator, a passthrough monitor and a slave
// responder with no memory behind it. Each accepted start runs NUM_TXN
// single-beat writes, then NUM_TXN single-beat reads. Every read beat is
// checked against the slave data rule RDATA = ~ARADDR.
// Optional feature macro: AXI_EXDES_SLV_WAIT_EN. When it is defined, the
// slave raises each READY only one cycle after it sees the matching VALID.
module axi_exdes_core #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_TXN   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        corrupt,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic [15:0] err_cnt
);

  localparam int         MIN_W    = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;
  localparam logic [7:0] LAST_IDX = 8'(NUM_TXN - 1);
  localparam logic [2:0] AX_SIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] RESP_OK  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Expected read data for a given address: the inverted address, zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] inv_addr(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = {DATA_W{1'b0}};
    for (int k = 0; k < MIN_W; k++) begin
      r[k] = ~a[k];
    end
    return r;
  endfunction

  // Master state
  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                bready_q, bready_d, rready_q, rready_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic                armed_q;
  // Slave state
  logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic                b_pend_q, b_pend_d, r_pend_q, r_pend_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  // Monitor counters
  logic [15:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  // Internal AXI4 bus (single beat, ID 0, INCR)
  logic [ADDR_W-1:0]   awaddr_s, araddr_s;
  logic [DATA_W-1:0]   wdata_s, rdata_s;
  logic [DATA_W/8-1:0] wstrb_s;
  logic [7:0]          ax_len_s;
  logic [2:0]          ax_size_s;
  logic [1:0]          ax_burst_s, bresp_s, rresp_s;
  logic                ax_id_s, rlast_s;
  logic                awvalid_s, awready_s, wvalid_s, wready_s, bvalid_s, bready_s;
  logic                arvalid_s, arready_s, rvalid_s, rready_s;
  logic                aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                start_acc_s, err_inc_s, unused_s;

  assign start_acc_s = (state_q == ST_IDLE) && start && armed_q;

  // Master drives the request side of the bus straight from its registers.
  assign awaddr_s   = addr_q;
  assign araddr_s   = addr_q;
  assign wdata_s    = DATA_W'({16'hA5A5, 8'h00, idx_q});
  assign wstrb_s    = {(DATA_W/8){1'b1}};
  assign ax_len_s   = 8'd0;
  assign ax_size_s  = AX_SIZE;
  assign ax_burst_s = 2'b01;
  assign ax_id_s    = 1'b0;
  assign awvalid_s  = awvalid_q;
  assign wvalid_s   = wvalid_q;
  assign arvalid_s  = arvalid_q;
  assign bready_s   = bready_q;
  assign rready_s   = rready_q;

  // The slave returns only OKAY responses and reads back the inverted read address.
  assign bvalid_s = b_pend_q;
  assign rvalid_s = r_pend_q;
  assign bresp_s  = RESP_OK;
  assign rresp_s  = RESP_OK;
  assign rlast_s  = 1'b1;
  assign rdata_s  = inv_addr(araddr_q) ^ {{(DATA_W-1){1'b0}}, corrupt};

  // The slave discards the write payload and ignores the fixed request attributes.
  assign unused_s = ^{awaddr_s, wdata_s, wstrb_s, ax_len_s, ax_size_s, ax_burst_s, ax_id_s, rlast_s};

`ifdef AXI_EXDES_SLV_WAIT_EN
  logic awready_q, wready_q, arready_q;

  // Each READY is raised one cycle after its VALID is seen and drops after the handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      awready_q <= awvalid_s && !awready_q && !aw_got_q && !b_pend_q;
      wready_q  <= wvalid_s && !wready_q && !w_got_q && !b_pend_q;
      arready_q <= arvalid_s && !arready_q && !r_pend_q;
    end
  end

  assign awready_s = awready_q;
  assign wready_s  = wready_q;
  assign arready_s = arready_q;
`else
  assign awready_s = !b_pend_q && !aw_got_q;
  assign wready_s  = !b_pend_q && !w_got_q;
  assign arready_s = !r_pend_q;
`endif

  assign aw_hs_s = awvalid_s && awready_s;
  assign w_hs_s  = wvalid_s && wready_s;
  assign b_hs_s  = bvalid_s && bready_s;
  assign ar_hs_s = arvalid_s && arready_s;
  assign r_hs_s  = rvalid_s && rready_s;

  // Slave: collect AW and W in any order, then owe one B; latch the AR address, then owe one R.
  always_comb begin
    aw_got_d = aw_got_q || aw_hs_s;
    w_got_d  = w_got_q || w_hs_s;
    b_pend_d = b_pend_q;
    r_pend_d = r_pend_q;
    araddr_d = araddr_q;
    if (aw_got_d && w_got_d) begin
      b_pend_d = 1'b1;
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
    end else if (b_hs_s) begin
      b_pend_d = 1'b0;
    end else begin
      b_pend_d = b_pend_q;
    end
    if (ar_hs_s) begin
      r_pend_d = 1'b1;
      araddr_d = araddr_s;
    end else if (r_hs_s) begin
      r_pend_d = 1'b0;
    end else begin
      r_pend_d = r_pend_q;
    end
  end

  // Master: write phase, read phase, and response checking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_d   = ST_WR;
          idx_d     = 8'd0;
          addr_d    = BASE_ADDR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((aw_hs_s || !awvalid_q) && (w_hs_s || !wvalid_q)) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (b_hs_s) begin
          bready_d  = 1'b0;
          err_inc_s = (bresp_s != RESP_OK);
          if (idx_q == LAST_IDX) begin
            state_d   = ST_RD;
            idx_d     = 8'd0;
            addr_d    = BASE_ADDR;
            arvalid_d = 1'b1;
          end else begin
            state_d   = ST_WR;
            idx_d     = idx_q + 8'd1;
            addr_d    = addr_q + ADDR_W'(4);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      ST_RD: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD_RESP: begin
        if (r_hs_s) begin
          rready_d  = 1'b0;
          err_inc_s = (rdata_s != inv_addr(addr_q)) || (rresp_s != RESP_OK);
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_RD;
            idx_d     = idx_q + 8'd1;
            addr_d    = addr_q + ADDR_W'(4);
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_RD_RESP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (err_inc_s && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_d;
    end
    pass_d = done_d && (err_d == 16'h0000);
  end

  // Monitor: saturating counts of B and R handshakes, restarted by each accepted start.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (start_acc_s) begin
      wr_cnt_d = 16'h0000;
      rd_cnt_d = 16'h0000;
    end else begin
      if (b_hs_s && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (r_hs_s && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q;
      end
    end
  end

  // All state registers. armed_q blocks a start that arrives on the first edge after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= 8'd0;
      addr_q    <= {ADDR_W{1'b0}};
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 16'h0000;
      armed_q   <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      b_pend_q  <= 1'b0;
      r_pend_q  <= 1'b0;
      araddr_q  <= {ADDR_W{1'b0}};
      wr_cnt_q  <= 16'h0000;
      rd_cnt_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      armed_q   <= 1'b1;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      b_pend_q  <= b_pend_d;
      r_pend_q  <= r_pend_d;
      araddr_q  <= araddr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_axi_exdes_core.sv
// Directed testbench for axi_exdes_core with the default parameters (NUM_TXN=8).
module tb_axi_exdes_core;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        corrupt = 1'b0;
  logic        busy, done, pass;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [31:0] aw0, rd0;

`ifdef AXI_EXDES_SLV_WAIT_EN
  localparam int EXP_CYC = 48;
`else
  localparam int EXP_CYC = 32;
`endif

  axi_exdes_core dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (start),
    .corrupt (corrupt),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .wr_cnt  (wr_cnt),
    .rd_cnt  (rd_cnt),
    .err_cnt (err_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start and follow the run until done, with a cycle budget.
  task automatic run(input int mid_start, output int cycles, output logic [31:0] aw_first,
                     output logic [31:0] rd_first);
    logic got_rd;
    got_rd = 1'b0;
    rd_first = 32'h0;
    repeat (2) @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    aw_first = dut.awvalid_s ? 32'(dut.awaddr_s) : 32'hDEAD_BEEF;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge aclk);
      #1;
      cycles++;
      start = (cycles == mid_start);
      if (dut.rvalid_s && !got_rd) begin
        rd_first = 32'(dut.rdata_s);
        got_rd = 1'b1;
      end
    end
    start = 1'b0;
    chk("run_finished", 32'(done), 32'h1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_cnts", {wr_cnt, rd_cnt}, 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);

    // Start coincident with reset release is ignored
    @(negedge aclk);
    aresetn = 1'b1;
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    chk("start_at_rst_release", 32'(busy), 32'h0);
    @(posedge aclk);
    #1;
    chk("start_at_rst_release_2", 32'(busy), 32'h0);

    // Nominal run
    run(0, cyc, aw0, rd0);
    chk("first_awaddr", aw0, 32'h0000_1000);
    chk("first_rdata", rd0, 32'hFFFF_EFFF);
    chk("run_cycles", cyc, EXP_CYC);
    chk("nom_busy", 32'(busy), 32'h0);
    chk("nom_pass", 32'(pass), 32'h1);
    chk("nom_wr", 32'(wr_cnt), 32'd8);
    chk("nom_rd", 32'(rd_cnt), 32'd8);
    chk("nom_err", 32'(err_cnt), 32'd0);

    // Corrupted read data
    corrupt = 1'b1;
    run(0, cyc, aw0, rd0);
    corrupt = 1'b0;
    chk("cor_rdata", rd0, 32'hFFFF_EFFE);
    chk("cor_err", 32'(err_cnt), 32'd8);
    chk("cor_pass", 32'(pass), 32'h0);
    chk("cor_rd", 32'(rd_cnt), 32'd8);

    // Start pulsed while busy is ignored
    run(5, cyc, aw0, rd0);
    chk("busy_start_cycles", cyc, EXP_CYC);
    chk("busy_start_wr", 32'(wr_cnt), 32'd8);
    chk("busy_start_rd", 32'(rd_cnt), 32'd8);
    chk("busy_start_pass", 32'(pass), 32'h1);
    repeat (3) @(posedge aclk);
    #1;
    chk("busy_start_no_rerun", 32'(busy), 32'h0);

    // Reset during the third write request
    @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    repeat (2 * (1 + (EXP_CYC / 16 - 2)) * 2) @(posedge aclk);
    #1;
    chk("pre_rst_wr", 32'(wr_cnt), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_pass", 32'(pass), 32'h0);
    chk("mid_rst_cnts", {wr_cnt, rd_cnt}, 32'h0);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    chk("mid_rst_bus", {31'h0, dut.awvalid_s | dut.wvalid_s | dut.arvalid_s | dut.bvalid_s | dut.rvalid_s}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    run(0, cyc, aw0, rd0);
    chk("post_rst_wr", 32'(wr_cnt), 32'd8);
    chk("post_rst_rd", 32'(rd_cnt), 32'd8);
    chk("post_rst_err", 32'(err_cnt), 32'd0);
    chk("post_rst_pass", 32'(pass), 32'h1);

    // Back-to-back run: done clears the cycle after the accepted start
    repeat (2) @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    chk("b2b_done_cleared", 32'(done), 32'h0);
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_cnt_restart", {wr_cnt, rd_cnt}, 32'h0);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    chk("b2b_cycles", cyc, EXP_CYC);
    chk("b2b_wr", 32'(wr_cnt), 32'd8);
    chk("b2b_rd", 32'(rd_cnt), 32'd8);
    chk("b2b_pass", 32'(pass), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
